// File: rtl/q_sample_sequencer.sv
// Synchronous-side controller for a Q-flop sampling stage: drives qclock, decodes the
// synchronised resolved rails into bits, bounds the wait with a timeout, buffers bits in a 2-deep FIFO.
module q_sample_sequencer #(
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned CNT_W   = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             rh_l,
  input  logic             rl_l,
  input  logic             ack,
  output logic             qclock,
  output logic             out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] resolve_cycles,
  output logic             timeout_err,
  output logic             rail_err
);

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StSample  = 2'd1;
  localparam logic [1:0] StRelease = 2'd2;

  localparam logic [CNT_W-1:0] TimeoutVal = CNT_W'(TIMEOUT);

  // Synchronisers, bit order {ack, rl_l, rh_l}; reset to 1 so the rails read idle.
  logic [2:0] sync1_d, sync1_q, sync2_d, sync2_q;
  logic       rh_s, rl_s, ack_s;

  logic [1:0]       state_d, state_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic [CNT_W-1:0] resolve_d, resolve_q;
  logic             qclock_d, qclock_q;
  logic             bit_d, bit_q;
  logic             bit_vld_d, bit_vld_q;
  logic             terr_d, terr_q;
  logic             rerr_d, rerr_q;

  logic [1:0] mem_d, mem_q;
  logic       wr_d, wr_q;
  logic       rd_d, rd_q;
  logic [1:0] count_d, count_q;
  logic       push, pop, full;

  always_comb begin
    sync1_d = {ack, rl_l, rh_l};
    sync2_d = sync1_q;
  end

  assign rh_s  = sync2_q[0];
  assign rl_s  = sync2_q[1];
  assign ack_s = sync2_q[2];

  assign full = (count_q == 2'd2);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    qclock_d  = qclock_q;
    bit_d     = bit_q;
    bit_vld_d = bit_vld_q;
    resolve_d = resolve_q;
    terr_d    = terr_q;
    rerr_d    = rerr_q;
    push      = 1'b0;
    case (state_q)
      StIdle: begin
        cnt_d    = '0;
        qclock_d = 1'b0;
        if (enable && ack_s && !full) begin
          state_d   = StSample;
          qclock_d  = 1'b1;
          bit_vld_d = 1'b0;
        end
      end
      StSample: begin
        if (!rh_s || !rl_s) begin
          // Both rails low resolves as 1 and is flagged.
          bit_d     = !rh_s;
          bit_vld_d = 1'b1;
          resolve_d = cnt_q;
          if (!rh_s && !rl_s) rerr_d = 1'b1;
          state_d   = StRelease;
          qclock_d  = 1'b0;
          cnt_d     = '0;
        end else if (cnt_q == TimeoutVal) begin
          terr_d    = 1'b1;
          bit_vld_d = 1'b0;
          state_d   = StRelease;
          qclock_d  = 1'b0;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StRelease: begin
        qclock_d = 1'b0;
        if (ack_s) begin
          push      = bit_vld_q;
          bit_vld_d = 1'b0;
          state_d   = StIdle;
          cnt_d     = '0;
        end else if (cnt_q == TimeoutVal) begin
          terr_d    = 1'b1;
          bit_vld_d = 1'b0;
          state_d   = StIdle;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d  = StIdle;
        qclock_d = 1'b0;
        cnt_d    = '0;
      end
    endcase
  end

  // With two entries a push at full lands in the slot being popped, which is correct FIFO order.
  always_comb begin
    pop   = (count_q != 2'd0) && out_ready;
    mem_d = mem_q;
    if (push) mem_d[wr_q] = bit_q;
    wr_d = wr_q ^ push;
    rd_d = rd_q ^ pop;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q   <= 3'b111;
      sync2_q   <= 3'b111;
      state_q   <= StIdle;
      cnt_q     <= '0;
      qclock_q  <= 1'b0;
      bit_q     <= 1'b0;
      bit_vld_q <= 1'b0;
      resolve_q <= '0;
      terr_q    <= 1'b0;
      rerr_q    <= 1'b0;
      mem_q     <= 2'b00;
      wr_q      <= 1'b0;
      rd_q      <= 1'b0;
      count_q   <= 2'd0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      qclock_q  <= qclock_d;
      bit_q     <= bit_d;
      bit_vld_q <= bit_vld_d;
      resolve_q <= resolve_d;
      terr_q    <= terr_d;
      rerr_q    <= rerr_d;
      mem_q     <= mem_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      count_q   <= count_d;
    end
  end

  assign qclock         = qclock_q;
  assign out_data       = mem_q[rd_q];
  assign out_valid      = (count_q != 2'd0);
  assign resolve_cycles = resolve_q;
  assign timeout_err    = terr_q;
  assign rail_err       = rerr_q;

endmodule

// File: tb/tb_q_sample_sequencer.sv
// Directed plus randomized bench for q_sample_sequencer; the Q-flop is emulated inline and the
// output buffer is modelled as a plain queue of expected bits.
module tb_q_sample_sequencer;

  logic       clock;
  logic       reset;
  logic       enable;
  logic       rh_l;
  logic       rl_l;
  logic       ack;
  logic       qclock;
  logic       out_data;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] resolve_cycles;
  logic       timeout_err;
  logic       rail_err;

  int total;
  int bad;
  logic mq[$];

  // Resolver is idle exactly when both rails are high.
  assign ack = rh_l & rl_l;

  q_sample_sequencer #(
    .TIMEOUT(15),
    .CNT_W  (4)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .enable        (enable),
    .rh_l          (rh_l),
    .rl_l          (rl_l),
    .ack           (ack),
    .qclock        (qclock),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .resolve_cycles(resolve_cycles),
    .timeout_err   (timeout_err),
    .rail_err      (rail_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic chk(input logic [31:0] got, input logic [31:0] exp, input string tag);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_rise(output logic found);
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clock);
      if (qclock === 1'b1) found = 1'b1;
    end
  endtask

  // kind: 0 -> bit 0, 1 -> bit 1, 2 -> both rails low. Rails drop before edge k after qclock rise.
  task automatic do_sample(input int kind, input int k, input bit pop_at_push);
    logic found;
    logic b;
    b = (kind != 0);
    enable = 1'b1;
    wait_rise(found);
    enable = 1'b0;
    chk(found, 1, "qclk_rise");
    if (found) begin
      repeat (k - 1) @(negedge clock);
      if (kind == 0) rl_l = 1'b0;
      else if (kind == 1) rh_l = 1'b0;
      else begin
        rh_l = 1'b0;
        rl_l = 1'b0;
      end
      repeat (2) @(negedge clock);
      chk(qclock, 1, "qclk_hold");
      @(negedge clock);
      chk(qclock, 0, "qclk_fall");
      chk(resolve_cycles, k + 1, "resolve_cycles");
      rh_l = 1'b1;
      rl_l = 1'b1;
      repeat (2) @(negedge clock);
      chk(out_valid, mq.size() != 0, "pre_push_valid");
      if (pop_at_push) out_ready = 1'b1;
      @(negedge clock);
      out_ready = 1'b0;
      if (pop_at_push) void'(mq.pop_front());
      mq.push_back(b);
      chk(out_valid, 1, "push_valid");
      chk(out_data, mq[0], "push_data");
    end
  endtask

  task automatic pop_chk();
    chk(out_valid, 1, "pop_valid");
    chk(out_data, mq[0], "pop_data");
    @(negedge clock);
    chk(out_data, mq[0], "hold_data");
    out_ready = 1'b1;
    @(negedge clock);
    out_ready = 1'b0;
    void'(mq.pop_front());
    chk(out_valid, mq.size() != 0, "post_pop_valid");
  endtask

  initial begin
    logic found;
    int   rises;
    int   kind;
    int   k;
    total     = 0;
    bad       = 0;
    reset     = 1'b1;
    enable    = 1'b0;
    rh_l      = 1'b1;
    rl_l      = 1'b1;
    out_ready = 1'b0;

    repeat (2) @(negedge clock);
    chk(qclock, 0, "rst_qclock");
    chk(out_valid, 0, "rst_valid");
    chk(out_data, 0, "rst_data");
    chk(resolve_cycles, 0, "rst_resolve");
    chk(timeout_err, 0, "rst_terr");
    chk(rail_err, 0, "rst_rerr");
    reset = 1'b0;
    @(negedge clock);

    // Single high sample, rails drop 3 cycles after qclock rises.
    do_sample(1, 3, 1'b0);
    chk(timeout_err, 0, "single_terr");
    chk(rail_err, 0, "single_rerr");
    pop_chk();

    // Back-pressure: two samples fill the buffer, then no further sampling.
    do_sample(1, $urandom_range(1, 10), 1'b0);
    do_sample(0, $urandom_range(1, 10), 1'b0);
    enable = 1'b1;
    rises  = 0;
    repeat (12) begin
      @(negedge clock);
      if (qclock) rises++;
    end
    enable = 1'b0;
    chk(rises, 0, "bp_no_sample");
    chk(out_data, 1, "bp_head");
    pop_chk();
    pop_chk();

    // Timeout: rails never drop.
    enable = 1'b1;
    wait_rise(found);
    enable = 1'b0;
    chk(found, 1, "to_rise");
    repeat (15) @(negedge clock);
    chk(qclock, 1, "to_qclk_before");
    chk(timeout_err, 0, "to_terr_before");
    @(negedge clock);
    chk(timeout_err, 1, "to_terr");
    chk(qclock, 0, "to_qclk");
    repeat (4) @(negedge clock);
    chk(out_valid, 0, "to_no_push");
    do_sample(0, 1, 1'b0);
    pop_chk();

    // Both rails low together.
    chk(rail_err, 0, "rr_before");
    do_sample(2, $urandom_range(1, 10), 1'b0);
    chk(rail_err, 1, "rr_set");
    pop_chk();

    // Simultaneous push and pop at one entry.
    do_sample(0, $urandom_range(1, 10), 1'b0);
    do_sample(1, $urandom_range(1, 10), 1'b1);
    pop_chk();

    // Randomized samples against the queue model.
    for (int i = 0; i < 8; i++) begin
      kind = $urandom_range(0, 1);
      k    = $urandom_range(1, 10);
      if (mq.size() == 2) pop_chk();
      do_sample(kind, k, 1'b0);
    end
    while (mq.size() != 0) pop_chk();

    // Reset during SAMPLE.
    do_sample(1, 2, 1'b0);
    enable = 1'b1;
    wait_rise(found);
    chk(found, 1, "rs_rise");
    reset = 1'b1;
    #1;
    chk(qclock, 0, "rs_qclock");
    chk(out_valid, 0, "rs_valid");
    chk(timeout_err, 0, "rs_terr");
    chk(rail_err, 0, "rs_rerr");
    chk(resolve_cycles, 0, "rs_resolve");
    mq.delete();
    enable = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    rh_l  = 1'b0;
    repeat (3) @(negedge clock);
    rh_l = 1'b1;
    repeat (6) @(negedge clock);
    chk(out_valid, 0, "rs_no_push");
    chk(qclock, 0, "rs_idle");
    do_sample(0, 5, 1'b0);
    pop_chk();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
